// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to a sync-read imem, buffers responses in a 2-entry FIFO.
// Latency: issue->out_valid 2 cycles; out_ready low stalls issue once FIFO occupancy plus in-flight reaches 2.
module instr_fetch_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        count;
  entry_t            head;
  entry_t            tail;

  logic              flush;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  entry_t            in_ent;

  // Occupancy after this cycle's pop, counting the response already on its way.
  assign occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign flush  = (state == RUN) && redirect_valid;
  assign pop    = (count != 2'd0) && out_ready;
  assign issue  = (state == RUN) && !redirect_valid && (occ < 3'd2);
  assign push   = inflight && !flush;
  assign in_ent = '{pc: inflight_pc, instr: imem_rdata};

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      count       <= 2'd0;
      head        <= '0;
      tail        <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            fetch_pc <= start_pc;
            state    <= RUN;
          end
        end
        RUN: begin
          if (redirect_valid) fetch_pc <= redirect_target;
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if ((count == 2'd0) && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Head entry drives the outputs directly, so entries shift toward it on pop.
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) head <= in_ent;
            else               tail <= in_ent;
            count <= count + 2'd1;
          end
          2'b01: begin
            head  <= tail;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head <= in_ent;
            end else begin
              head <= tail;
              tail <= in_ent;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a synchronous-read memory model mem[k] = 32'h1000_0000 + k.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              halt_req;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .start_pc        (start_pc),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .busy            (busy)
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + {18'd0, a};
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_head(input string tag, input int pc);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(pc);
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_pc"}, 32'(out_pc), 32'(a));
    check_eq({tag, "_instr"}, out_instr, mem_word(a));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = '0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b1;

    #3;
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_pc", 32'(out_pc), 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Basic stream from 5; redirect and halt alongside start must be ignored in IDLE.
    start = 1'b1; start_pc = 14'd5; halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 14'd40;
    step();
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    check_eq("c1_addr", 32'(imem_addr), 32'd5);
    check_eq("c1_busy", 32'(busy), 32'd1);
    check_eq("c1_vld", 32'(out_valid), 32'd0);
    step();
    check_eq("c2_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_head("seq", 5 + i);
    end

    // Backpressure for 4 cycles: head 10 holds, address stalls at 12.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("bp_hold", 10);
      check_eq("bp_addr", 32'(imem_addr), 32'd12);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head("bp_resume", 11 + i);
    end
    check_eq("bp_addr_run", 32'(imem_addr), 32'd17);

    // Fill the FIFO, then halt with out_ready=1: 15, 16 buffered and 17 issued in the halt cycle.
    out_ready = 1'b0;
    step();
    check_head("halt_full", 15);
    check_eq("halt_full_addr", 32'(imem_addr), 32'd17);
    halt_req = 1'b1; out_ready = 1'b1;
    step();
    halt_req = 1'b0;
    check_head("halt_d0", 16);
    check_eq("halt_d0_busy", 32'(busy), 32'd1);
    check_eq("halt_d0_addr", 32'(imem_addr), 32'd18);
    redirect_valid = 1'b1; redirect_target = 14'd40; start = 1'b1; start_pc = 14'd99;
    step();
    redirect_valid = 1'b0; start = 1'b0;
    check_head("halt_d1", 17);
    check_eq("halt_d1_addr", 32'(imem_addr), 32'd18);
    step();
    check_eq("halt_d2_vld", 32'(out_valid), 32'd0);
    check_eq("halt_d2_busy", 32'(busy), 32'd1);
    step();
    check_eq("halt_idle_busy", 32'(busy), 32'd0);
    check_eq("halt_idle_vld", 32'(out_valid), 32'd0);
    check_eq("halt_idle_addr", 32'(imem_addr), 32'd18);

    // Redirect to 40 while 8 is presented and accepted.
    start = 1'b1; start_pc = 14'd5;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("rd_pre", 5 + i);
    end
    redirect_valid = 1'b1; redirect_target = 14'd40;
    step();
    redirect_valid = 1'b0;
    check_eq("rd_t1_vld", 32'(out_valid), 32'd0);
    check_eq("rd_t1_addr", 32'(imem_addr), 32'd40);
    step();
    check_eq("rd_t2_vld", 32'(out_valid), 32'd0);
    step();
    check_head("rd_tgt", 40);
    step();
    check_head("rd_next", 41);

    // Asynchronous reset mid-stream, checked before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 32'(out_valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_addr", 32'(imem_addr), 32'd0);
    check_eq("arst_pc", 32'(out_pc), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_vld", 32'(out_valid), 32'd0);
    check_eq("post_rst_addr", 32'(imem_addr), 32'd0);

    // Address wrap from 16382.
    start = 1'b1; start_pc = 14'd16382;
    step();
    start = 1'b0;
    check_eq("wrap_addr", 32'(imem_addr), 32'd16382);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("wrap", (16382 + i) % 16384);
    end

    // Halt together with redirect: flush and retarget, then drain straight to IDLE.
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 14'd100;
    step();
    halt_req = 1'b0; redirect_valid = 1'b0;
    check_eq("hr_vld", 32'(out_valid), 32'd0);
    check_eq("hr_addr", 32'(imem_addr), 32'd100);
    check_eq("hr_busy", 32'(busy), 32'd1);
    step();
    check_eq("hr_idle_busy", 32'(busy), 32'd0);
    check_eq("hr_idle_addr", 32'(imem_addr), 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
